// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered flags, programmable thresholds
// and a selectable registered or first-word-fall-through read port.
module sync_fifo #(
  parameter int DSIZE       = 8,
  parameter int ASIZE       = 4,
  parameter int FALLTHROUGH = 0,
  parameter int AFULL_LVL   = (1 << ASIZE) - 1,
  parameter int AEMPTY_LVL  = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  output logic             werr,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  output logic             rerr,
  output logic [ASIZE:0]   count
);

  localparam int DEPTH = 1 << ASIZE;
  localparam int AW    = ASIZE + 1;
  localparam logic [ASIZE:0] AF_LVL = AW'(AFULL_LVL);
  localparam logic [ASIZE:0] AE_LVL = AW'(AEMPTY_LVL);

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0] wptr, rptr;
  logic [ASIZE:0] wptr_n, rptr_n;
  logic [ASIZE:0] rptr_inc, count_n;
  logic           wacc, racc;
  logic           wfull_n, rempty_n;

  // next-state pointers, occupancy and flags
  always_comb begin
    wacc     = winc & ~wfull;
    racc     = rinc & ~rempty;
    rptr_inc = rptr + AW'(1);
    wptr_n   = wptr + AW'(wacc);
    rptr_n   = racc ? rptr_inc : rptr;
    count_n  = count + AW'(wacc) - AW'(racc);
    wfull_n  = (wptr_n[ASIZE] != rptr_n[ASIZE]) &&
               (wptr_n[ASIZE-1:0] == rptr_n[ASIZE-1:0]);
    rempty_n = (wptr_n == rptr_n);
  end

  // storage array, not reset; reset drops a coincident write
  always_ff @(posedge clk) begin
    if (!srst && wacc)
      mem[wptr[ASIZE-1:0]] <= wdata;
  end

  // pointers, count, status flags and error pulses
  always_ff @(posedge clk) begin
    if (srst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      wfull   <= 1'b0;
      awfull  <= 1'b0;
      rempty  <= 1'b1;
      arempty <= 1'b1;
      werr    <= 1'b0;
      rerr    <= 1'b0;
    end else begin
      wptr    <= wptr_n;
      rptr    <= rptr_n;
      count   <= count_n;
      wfull   <= wfull_n;
      awfull  <= (count_n >= AF_LVL);
      rempty  <= rempty_n;
      arempty <= (count_n <= AE_LVL);
      werr    <= winc & wfull;
      rerr    <= rinc & rempty;
    end
  end

  // read data register: popped word, or presented head in fall-through
  always_ff @(posedge clk) begin
    if (srst) begin
      rdata <= '0;
    end else if (FALLTHROUGH == 0) begin
      if (racc)
        rdata <= mem[rptr[ASIZE-1:0]];
    end else begin
      if (racc) begin
        if (count > AW'(1))
          rdata <= mem[rptr_inc[ASIZE-1:0]];
        else if (wacc)
          rdata <= wdata;
      end else if (rempty && wacc) begin
        rdata <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: both read modes driven in lockstep
// and compared with a queue model of the FIFO.
module tb_sync_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       srst, winc, rinc;
  logic [7:0] wdata;

  logic       wfull0, awfull0, werr0, rempty0, arempty0, rerr0;
  logic [7:0] rdata0;
  logic [4:0] count0;
  logic       wfull1, awfull1, werr1, rempty1, arempty1, rerr1;
  logic [7:0] rdata1;
  logic [4:0] count1;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] rd0_e, rd1_e;
  logic       werr_e, rerr_e;

  always #5 clk = ~clk;

  sync_fifo #(
    .DSIZE(8), .ASIZE(4), .FALLTHROUGH(0),
    .AFULL_LVL(12), .AEMPTY_LVL(2)
  ) u_reg (
    .clk(clk), .srst(srst),
    .winc(winc), .wdata(wdata),
    .wfull(wfull0), .awfull(awfull0), .werr(werr0),
    .rinc(rinc), .rdata(rdata0),
    .rempty(rempty0), .arempty(arempty0), .rerr(rerr0),
    .count(count0)
  );

  sync_fifo #(
    .DSIZE(8), .ASIZE(4), .FALLTHROUGH(1),
    .AFULL_LVL(12), .AEMPTY_LVL(2)
  ) u_fwft (
    .clk(clk), .srst(srst),
    .winc(winc), .wdata(wdata),
    .wfull(wfull1), .awfull(awfull1), .werr(werr1),
    .rinc(rinc), .rdata(rdata1),
    .rempty(rempty1), .arempty(arempty1), .rerr(rerr1),
    .count(count1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count0",   32'(count0),   32'(n));
    chk("count1",   32'(count1),   32'(n));
    chk("wfull0",   32'(wfull0),   32'(n == DEPTH));
    chk("wfull1",   32'(wfull1),   32'(n == DEPTH));
    chk("rempty0",  32'(rempty0),  32'(n == 0));
    chk("rempty1",  32'(rempty1),  32'(n == 0));
    chk("awfull0",  32'(awfull0),  32'(n >= 12));
    chk("awfull1",  32'(awfull1),  32'(n >= 12));
    chk("arempty0", 32'(arempty0), 32'(n <= 2));
    chk("arempty1", 32'(arempty1), 32'(n <= 2));
    chk("werr0",    32'(werr0),    32'(werr_e));
    chk("werr1",    32'(werr1),    32'(werr_e));
    chk("rerr0",    32'(rerr0),    32'(rerr_e));
    chk("rerr1",    32'(rerr1),    32'(rerr_e));
    chk("rdata0",   32'(rdata0),   32'(rd0_e));
    chk("rdata1",   32'(rdata1),   32'(rd1_e));
  endtask

  // one clock: apply inputs, advance the model, compare after the edge
  task automatic step(input logic rst, input logic w,
                      input logic r, input logic [7:0] d);
    logic full, empty;
    srst  = rst;
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge clk);
    if (rst) begin
      q.delete();
      rd0_e  = '0;
      rd1_e  = '0;
      werr_e = 1'b0;
      rerr_e = 1'b0;
    end else begin
      full   = (q.size() == DEPTH);
      empty  = (q.size() == 0);
      werr_e = w && full;
      rerr_e = r && empty;
      if (r && !empty) rd0_e = q.pop_front();
      if (w && !full) q.push_back(d);
      if (q.size() > 0) rd1_e = q[0];
    end
    #1;
    check_all();
  endtask

  initial begin
    srst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = '0;
    q.delete();
    rd0_e = '0; rd1_e = '0; werr_e = 1'b0; rerr_e = 1'b0;

    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk("reset_count", 32'(count0), 32'd0);

    // simple transfer
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    chk("count_3", 32'(count0), 32'd3);
    step(0, 0, 1, 8'h00);
    chk("pop_11", 32'(rdata0), 32'h11);
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    chk("pop_33", 32'(rdata0), 32'h33);

    // underflow
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // fill past full, thresholds on the way up
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, 0, 8'(8'h40 + i));
    step(0, 1, 0, 8'hAA);
    step(0, 1, 0, 8'hAA);
    step(0, 0, 0, 8'h00);

    // simultaneous at full: only the read goes through
    step(0, 1, 1, 8'hAA);
    chk("simul_count", 32'(count0), 32'd15);

    // drain, thresholds on the way down
    for (int i = 0; i < DEPTH; i++)
      step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);

    // fall-through bypass and pop+write at count 1
    step(0, 1, 0, 8'h5A);
    chk("fwft_5a", 32'(rdata1), 32'h5A);
    step(0, 1, 1, 8'h6B);
    chk("fwft_6b", 32'(rdata1), 32'h6B);
    step(0, 0, 1, 8'h00);

    // random traffic with pointer wraps
    for (int i = 0; i < 300; i++)
      step(0, $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 5,
           8'($urandom));

    // reset with a write pending at count 7
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 7; i++)
      step(0, 1, 0, 8'(8'h70 + i));
    step(1, 1, 0, 8'hEE);
    step(0, 0, 1, 8'h00);
    chk("post_rst_count", 32'(count0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
